// File: rtl/dma_byp_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_byp_out_pkg
// Purpose  : Shared constants, the FIFO entry type and a small width helper
//            for the PCIe DMA bypass-out arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dma_byp_out_pkg;

  localparam int CIDX_W    = 16;
  // Widest descriptor the entry type can carry; narrower DSC_W values are
  // zero-padded into this field and the pad bits fall away in synthesis.
  localparam int DSC_MAX_W = 256;

  typedef struct packed {
    logic [DSC_MAX_W-1:0] dsc;
    logic [CIDX_W-1:0]    cidx;
  } byp_out_ent_t;

  // Channel-index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_pcie_byp_out_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_pcie_byp_out_arb_if
// Purpose  : Bundles the per-channel bypass-out inputs and the merged
//            output handshake of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_pcie_byp_out_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DSC_W  = 256
) ();

  localparam int CIDX_W = dma_byp_out_pkg::CIDX_W;
  localparam int CH_W   = dma_byp_out_pkg::ch_w(NUM_CH);

  logic [NUM_CH*DSC_W-1:0]  in_dsc;
  logic [NUM_CH*CIDX_W-1:0] in_cidx;
  logic [NUM_CH-1:0]        in_vld;
  logic [NUM_CH-1:0]        in_rdy;
  logic [NUM_CH-1:0]        ch_flush;
  logic [DSC_W-1:0]         out_dsc;
  logic [CIDX_W-1:0]        out_cidx;
  logic [CH_W-1:0]          out_ch;
  logic                     out_vld;
  logic                     out_rdy;
  logic [NUM_CH-1:0]        cidx_err;

  // Arbiter side
  modport slave (
    input  in_dsc, in_cidx, in_vld, ch_flush, out_rdy,
    output in_rdy, out_dsc, out_cidx, out_ch, out_vld, cidx_err
  );

  // Source/sink side
  modport master (
    output in_dsc, in_cidx, in_vld, ch_flush, out_rdy,
    input  in_rdy, out_dsc, out_cidx, out_ch, out_vld, cidx_err
  );

endinterface
`default_nettype wire

// File: rtl/dma_byp_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_byp_out_fifo
// Purpose  : Per-channel descriptor buffer with a synchronous flush that
//            empties it and discards a concurrent push.
// Revision : 1.0 - initial release
// ============================================================================
module dma_byp_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/dma_pcie_byp_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : dma_pcie_byp_out_arb
// Purpose  : Merges NUM_CH bypass-out descriptor streams into one registered
//            output through per-channel FIFOs and round-robin selection.
//            Optional feature macro DMA_BYP_OUT_CIDX_CHK_EN adds a per-channel
//            consumer-index sequence checker driving cidx_err.
//            DSC_W may be at most dma_byp_out_pkg::DSC_MAX_W.
// Revision : 1.0 - initial release
// ============================================================================
module dma_pcie_byp_out_arb
  import dma_byp_out_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DSC_W      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  dma_pcie_byp_out_arb_if.slave bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int ENT_W = $bits(byp_out_ent_t);

  logic              rdy_en;
  logic [NUM_CH-1:0] in_rdy_w;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] cidx_err_w;
  byp_out_ent_t      wr_ent [NUM_CH];
  byp_out_ent_t      rd_ent [NUM_CH];
  byp_out_ent_t      sel_ent;

  logic [CH_W-1:0]   grant;
  logic              any_req;
  logic              load;
  logic [CH_W-1:0]   rr_ptr;

  logic              out_vld_q;
  logic [DSC_W-1:0]  out_dsc_q;
  logic [CIDX_W-1:0] out_cidx_q;
  logic [CH_W-1:0]   out_ch_q;

  // Holds in_rdy low during reset and releases it on the first clock after.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) rdy_en <= 1'b0;
    else              rdy_en <= 1'b1;
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign in_rdy_w[i] = rdy_en & ~full[i] & ~bus.ch_flush[i];
      assign push[i]     = bus.in_vld[i] & in_rdy_w[i];
      // A flushing channel must not feed the output in the same cycle.
      assign req[i]      = ~empty[i] & ~bus.ch_flush[i];
      assign pop[i]      = load && (grant == CH_W'(i));
      assign wr_ent[i]   = {DSC_MAX_W'(bus.in_dsc[i*DSC_W +: DSC_W]),
                            bus.in_cidx[i*CIDX_W +: CIDX_W]};

      dma_byp_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
      ) u_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .flush (bus.ch_flush[i]),
        .push  (push[i]),
        .din   (wr_ent[i]),
        .pop   (pop[i]),
        .dout  (rd_ent[i]),
        .empty (empty[i]),
        .full  (full[i])
      );

`ifdef DMA_BYP_OUT_CIDX_CHK_EN
      logic [CIDX_W-1:0] prev_cidx;
      logic              seeded;
      logic              err;

      // First accept after reset/flush seeds; later accepts must step by one.
      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
          prev_cidx <= '0;
          seeded    <= 1'b0;
          err       <= 1'b0;
        end else if (bus.ch_flush[i]) begin
          seeded    <= 1'b0;
          err       <= 1'b0;
        end else if (push[i]) begin
          if (seeded && (wr_ent[i].cidx != CIDX_W'(prev_cidx + 1'b1))) err <= 1'b1;
          prev_cidx <= wr_ent[i].cidx;
          seeded    <= 1'b1;
        end
      end

      assign cidx_err_w[i] = err;
`else
      assign cidx_err_w[i] = 1'b0;
`endif
    end : g_ch
  endgenerate

  // Round-robin search starting at rr_ptr, first requesting channel wins.
  always_comb begin
    int idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = CH_W'(idx);
      end
    end
  end

  assign load    = (!out_vld_q || bus.out_rdy) && any_req;
  assign sel_ent = rd_ent[grant];

  // Output register: reload when empty or draining, hold while stalled.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      out_vld_q  <= 1'b0;
      out_dsc_q  <= '0;
      out_cidx_q <= '0;
      out_ch_q   <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      out_vld_q  <= 1'b1;
      out_dsc_q  <= sel_ent.dsc[DSC_W-1:0];
      out_cidx_q <= sel_ent.cidx;
      out_ch_q   <= grant;
      rr_ptr     <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end else if (bus.out_rdy) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign bus.in_rdy   = in_rdy_w;
  assign bus.cidx_err = cidx_err_w;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_dsc  = out_dsc_q;
  assign bus.out_cidx = out_cidx_q;
  assign bus.out_ch   = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_pcie_byp_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_pcie_byp_out_arb
// Purpose  : Directed scoreboard bench for the bypass-out arbiter.
//            Honours DMA_BYP_OUT_CIDX_CHK_EN for the cidx-error expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_pcie_byp_out_arb;
  import dma_byp_out_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int DSC_W      = 256;
  localparam int FIFO_DEPTH = 4;
`ifdef DMA_BYP_OUT_CIDX_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]   ch;
    logic [15:0]  cidx;
    logic [255:0] dsc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_pcie_byp_out_arb_if #(.NUM_CH(NUM_CH), .DSC_W(DSC_W)) bus ();

  dma_pcie_byp_out_arb #(
    .NUM_CH     (NUM_CH),
    .DSC_W      (DSC_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .bus         (bus)
  );

  exp_t exp_q[$];
  int   beat_cyc[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted output beat is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_vld && bus.out_rdy) begin
      checks++;
      beats++;
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat actual ch=%0d cidx=%0d required no beat",
                 bus.out_ch, bus.out_cidx);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.out_ch !== mon_e.ch || bus.out_cidx !== mon_e.cidx || bus.out_dsc !== mon_e.dsc) begin
          errors++;
          $display("FAIL beat actual ch=%0d cidx=%0d dsc_hi=%h required ch=%0d cidx=%0d dsc_hi=%h",
                   bus.out_ch, bus.out_cidx, bus.out_dsc[255:224],
                   mon_e.ch, mon_e.cidx, mon_e.dsc[255:224]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] mk_dsc(input int ch, input int idx);
    logic [255:0] d;
    d          = '0;
    d[255:224] = 32'hC0DE_0000 | 32'(ch << 8) | 32'(idx);
    d[127:96]  = 32'(idx * 7 + ch);
    d[31:0]    = ~d[255:224];
    return d;
  endfunction

  function automatic exp_t mk_exp(input int ch, input logic [15:0] cidx, input logic [255:0] dsc);
    exp_t e;
    e.ch   = 2'(ch);
    e.cidx = cidx;
    e.dsc  = dsc;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] cidx, input logic [255:0] dsc);
    bus.in_dsc[ch*DSC_W +: DSC_W] = dsc;
    bus.in_cidx[ch*16 +: 16]      = cidx;
  endtask

  // One-cycle push attempt; acc reports in_rdy seen before the edge.
  task automatic push1(input int ch, input logic [15:0] cidx, input logic [255:0] dsc, output bit acc);
    set_ch(ch, cidx, dsc);
    bus.in_vld[ch] = 1'b1;
    @(negedge clk);
    acc = bus.in_rdy[ch];
    @(posedge clk);
    #1;
    bus.in_vld[ch] = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_vld   = '0;
    bus.ch_flush = '0;
    bus.out_rdy  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int b0;
    bus.in_dsc   = '0;
    bus.in_cidx  = '0;
    bus.in_vld   = '0;
    bus.ch_flush = '0;
    bus.out_rdy  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld",  64'(bus.out_vld), 64'd0);
    chk("rst_in_rdy",   64'(bus.in_rdy), 64'd0);
    chk("rst_out_dsc",  64'(|bus.out_dsc), 64'd0);
    chk("rst_out_cidx", 64'(bus.out_cidx), 64'd0);
    chk("rst_out_ch",   64'(bus.out_ch), 64'd0);
    chk("rst_cidx_err", 64'(bus.cidx_err), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("in_rdy_after_rst", 64'(bus.in_rdy), 64'hF);

    // Single descriptor latency
    bus.out_rdy = 1'b1;
    exp_q.push_back(mk_exp(0, 16'd5, mk_dsc(0, 0)));
    push1(0, 16'd5, mk_dsc(0, 0), acc);
    chk("t1_acc", 64'(acc), 64'd1);
    @(negedge clk);
    chk("t1_vld_t1", 64'(bus.out_vld), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_vld_t2", 64'(bus.out_vld), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_one_beat", 64'(bus.out_vld), 64'd0);
    wait_drain(10);

    // Round robin, all channels valid
    do_reset();
    bus.out_rdy = 1'b1;
    beat_cyc.delete();
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < 4; ch++)
        exp_q.push_back(mk_exp(ch, 16'(ch * 16 + k), mk_dsc(ch, k)));
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 4; ch++) set_ch(ch, 16'(ch * 16 + k), mk_dsc(ch, k));
      bus.in_vld = 4'hF;
      @(negedge clk);
      chk("t2_in_rdy", 64'(bus.in_rdy), 64'hF);
      @(posedge clk);
      #1;
    end
    bus.in_vld = '0;
    wait_drain(30);
    chk("t2_beats", 64'(beat_cyc.size()), 64'd12);
    if (beat_cyc.size() == 12) chk("t2_rate", 64'(beat_cyc[11] - beat_cyc[0]), 64'd11);

    // Back-pressure fill of channel 1
    do_reset();
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) exp_q.push_back(mk_exp(1, 16'(100 + k), mk_dsc(1, k)));
      push1(1, 16'(100 + k), mk_dsc(1, k), acc);
      chk("t3_acc", 64'(acc), (k < 5) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    chk("t3_full_rdy", 64'(bus.in_rdy[1]), 64'd0);
    chk("t3_hold_vld", 64'(bus.out_vld), 64'd1);
    chk("t3_hold_cidx", 64'(bus.out_cidx), 64'd100);
    tick();
    @(negedge clk);
    chk("t3_stable_cidx", 64'(bus.out_cidx), 64'd100);
    chk("t3_stable_ch", 64'(bus.out_ch), 64'd1);
    tick();
    bus.out_rdy = 1'b1;
    wait_drain(20);

    // Flush of channel 2
    do_reset();
    bus.out_rdy = 1'b0;
    exp_q.push_back(mk_exp(0, 16'd200, mk_dsc(0, 9)));
    push1(0, 16'd200, mk_dsc(0, 9), acc);
    chk("t4_acc0", 64'(acc), 64'd1);
    for (int k = 0; k < 3; k++) begin
      push1(2, 16'(300 + k), mk_dsc(2, k), acc);
      chk("t4_acc2", 64'(acc), 64'd1);
    end
    bus.ch_flush[2] = 1'b1;
    @(negedge clk);
    chk("t4_rdy_flush", 64'(bus.in_rdy[2]), 64'd0);
    @(posedge clk);
    #1;
    bus.ch_flush[2] = 1'b0;
    exp_q.push_back(mk_exp(2, 16'd400, mk_dsc(2, 7)));
    push1(2, 16'd400, mk_dsc(2, 7), acc);
    chk("t4_acc_new", 64'(acc), 64'd1);
    bus.out_rdy = 1'b1;
    wait_drain(20);
    repeat (4) tick();

    // Consumer-index sequence on channel 3
    do_reset();
    bus.out_rdy = 1'b1;
    exp_q.push_back(mk_exp(3, 16'd65535, mk_dsc(3, 0)));
    exp_q.push_back(mk_exp(3, 16'd0, mk_dsc(3, 1)));
    exp_q.push_back(mk_exp(3, 16'd2, mk_dsc(3, 2)));
    push1(3, 16'd65535, mk_dsc(3, 0), acc);
    push1(3, 16'd0, mk_dsc(3, 1), acc);
    @(negedge clk);
    chk("t5_err_wrap", 64'(bus.cidx_err[3]), 64'd0);
    tick();
    push1(3, 16'd2, mk_dsc(3, 2), acc);
    @(negedge clk);
    chk("t5_err_gap", 64'(bus.cidx_err[3]), 64'(CHK));
    tick();
    @(negedge clk);
    chk("t5_err_sticky", 64'(bus.cidx_err[3]), 64'(CHK));
    chk("t5_err_others", 64'(bus.cidx_err[2:0]), 64'd0);
    wait_drain(20);
    bus.ch_flush[3] = 1'b1;
    tick();
    bus.ch_flush[3] = 1'b0;
    @(negedge clk);
    chk("t5_err_clear", 64'(bus.cidx_err[3]), 64'd0);
    tick();

    // Reset mid-operation
    do_reset();
    bus.out_rdy = 1'b0;
    push1(0, 16'd500, mk_dsc(0, 5), acc);
    push1(1, 16'd600, mk_dsc(1, 6), acc);
    push1(1, 16'd601, mk_dsc(1, 7), acc);
    @(negedge clk);
    chk("t6_pre_vld", 64'(bus.out_vld), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(bus.out_vld), 64'd0);
    chk("t6_rst_rdy", 64'(bus.in_rdy), 64'd0);
    chk("t6_rst_cidx", 64'(bus.out_cidx), 64'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.out_rdy = 1'b1;
    b0          = beats;
    tick();
    chk("t6_rdy_release", 64'(bus.in_rdy), 64'hF);
    repeat (6) tick();
    chk("t6_no_stale", 64'(beats - b0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
